// File: rtl/gpo_event_scheduler.sv
// gpo_event_scheduler: timed-event sequencer for the gpo core bank.
// Buffers 128-bit timed entries in a first-word-fall-through FIFO and runs a 64-bit
// timeline counter. When the head timestamp equals the counter, the entry is popped and
// broadcast on event_data with a one-cycle counter_matched strobe. A head timestamp
// below the counter is popped as late and reported through sticky flags.
//
// Ports:
//   CLK100MHZ, resetn           clock, asynchronous active-low reset
//   write_en, write_data        push an entry {dest/upper[127:96], ts[95:32], lower[31:0]}
//   start, stop                 IDLE->RUN / RUN->IDLE pulses (stop wins)
//   counter_clear, flush        zero the timeline counter / empty the FIFO
//   error_clear                 clear sticky flags and late_count; HALT->IDLE
//   fifo_full/empty/count       FIFO status
//   running, halted             FSM status
//   counter                     timeline counter
//   event_data, counter_matched last dispatched entry and its strobe
//   late_error, overflow_error  sticky error flags
//   late_count, late_data       saturating late counter and most recent late entry
module gpo_event_scheduler #(
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter bit          HALT_ON_LATE    = 1'b1
) (
  input  logic                     CLK100MHZ,
  input  logic                     resetn,
  input  logic                     write_en,
  input  logic [127:0]             write_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     counter_clear,
  input  logic                     flush,
  input  logic                     error_clear,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [FIFO_ADDR_WIDTH:0] fifo_count,
  output logic                     running,
  output logic                     halted,
  output logic [63:0]              counter,
  output logic [127:0]             event_data,
  output logic                     counter_matched,
  output logic                     late_error,
  output logic                     overflow_error,
  output logic [15:0]              late_count,
  output logic [127:0]             late_data
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_WIDTH;

  typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [FIFO_ADDR_WIDTH:0]   cnt_t;
  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e         state_q, state_d;
  logic [63:0]    counter_q, counter_d;
  ptr_t           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t           count_q, count_d;
  logic [127:0]   mem_q [Depth];
  logic [127:0]   event_data_q, event_data_d;
  logic           match_q, match_d;
  logic           late_q, late_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    late_cnt_q, late_cnt_d;
  logic [127:0]   late_data_q, late_data_d;

  logic [127:0]   head;
  logic [63:0]    head_ts;
  logic           full, empty, dispatch_en, pop, push_ok, ovf_set, late_hit;
  logic [15:0]    late_base;

  assign head    = mem_q[rd_ptr_q];
  assign head_ts = head[95:32];
  assign full    = (count_q == cnt_t'(Depth));
  assign empty   = (count_q == '0);

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    event_data_d = event_data_q;
    match_d      = 1'b0;
    late_hit     = 1'b0;
    pop          = 1'b0;

    // A stop cycle does not dispatch, so a strobe never lands outside RUN.
    dispatch_en = (state_q == StRun) && !stop && !flush && !empty;
    if (dispatch_en) begin
      if (head_ts == counter_q) begin
        pop          = 1'b1;
        match_d      = 1'b1;
        event_data_d = head;
      end else if (head_ts < counter_q) begin
        pop      = 1'b1;
        late_hit = 1'b1;
      end
    end

    // A pop frees a slot in the same cycle, so a push while full is accepted then.
    push_ok = write_en && !flush && (!full || pop);
    ovf_set = write_en && !flush && full && !pop;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push_ok && !pop)      count_d = count_q + cnt_t'(1);
      else if (pop && !push_ok) count_d = count_q - cnt_t'(1);
    end

    if (counter_clear)          counter_d = '0;
    else if (state_q == StRun)  counter_d = counter_q + 64'd1;

    unique case (state_q)
      StIdle: if (start && !stop) state_d = StRun;
      StRun: begin
        if (stop)                          state_d = StIdle;
        else if (late_hit && HALT_ON_LATE) state_d = StHalt;
      end
      StHalt: if (error_clear) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Set wins over clear for the sticky flags and the late counter.
    late_d      = late_hit | (late_q & ~error_clear);
    ovf_d       = ovf_set | (ovf_q & ~error_clear);
    late_base   = error_clear ? 16'd0 : late_cnt_q;
    late_cnt_d  = (late_hit && late_base != 16'hFFFF) ? late_base + 16'd1 : late_base;
    late_data_d = late_hit ? head : late_data_q;
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      event_data_q <= '0;
      match_q      <= 1'b0;
      late_q       <= 1'b0;
      ovf_q        <= 1'b0;
      late_cnt_q   <= '0;
      late_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      event_data_q <= event_data_d;
      match_q      <= match_d;
      late_q       <= late_d;
      ovf_q        <= ovf_d;
      late_cnt_q   <= late_cnt_d;
      late_data_q  <= late_data_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) mem_q[wr_ptr_q] <= write_data;
  end

  assign fifo_full       = full;
  assign fifo_empty      = empty;
  assign fifo_count      = count_q;
  assign running         = (state_q == StRun);
  assign halted          = (state_q == StHalt);
  assign counter         = counter_q;
  assign event_data      = event_data_q;
  assign counter_matched = match_q;
  assign late_error      = late_q;
  assign overflow_error  = ovf_q;
  assign late_count      = late_cnt_q;
  assign late_data       = late_data_q;

endmodule

// File: tb/tb_gpo_event_scheduler.sv
module tb_gpo_event_scheduler;

  logic         CLK100MHZ = 1'b0;
  logic         resetn = 1'b0;
  logic         write_en = 1'b0;
  logic [127:0] write_data = '0;
  logic         start = 1'b0, stop = 1'b0, counter_clear = 1'b0, flush = 1'b0;
  logic         error_clear = 1'b0;
  logic         fifo_full, fifo_empty, running, halted, counter_matched;
  logic         late_error, overflow_error;
  logic [4:0]   fifo_count;
  logic [63:0]  counter;
  logic [127:0] event_data, late_data;
  logic [15:0]  late_count;

  gpo_event_scheduler #(
    .FIFO_ADDR_WIDTH(4),
    .HALT_ON_LATE   (1'b1)
  ) dut (
    .CLK100MHZ      (CLK100MHZ),
    .resetn         (resetn),
    .write_en       (write_en),
    .write_data     (write_data),
    .start          (start),
    .stop           (stop),
    .counter_clear  (counter_clear),
    .flush          (flush),
    .error_clear    (error_clear),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .fifo_count     (fifo_count),
    .running        (running),
    .halted         (halted),
    .counter        (counter),
    .event_data     (event_data),
    .counter_matched(counter_matched),
    .late_error     (late_error),
    .overflow_error (overflow_error),
    .late_count     (late_count),
    .late_data      (late_data)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  int strobe_cnt = 0;
  int s0;
  logic [127:0] sb [$];
  logic [127:0] exp_e;
  logic [63:0]  exp_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [63:0] ts, input logic [31:0] tag);
    return {tag ^ 32'hA5A5_0000, ts, ~tag};
  endfunction

  task automatic push(input logic [63:0] ts, input logic [31:0] tag, input bit expect_dispatch);
    write_en   = 1'b1;
    write_data = mk(ts, tag);
    if (expect_dispatch) sb.push_back(write_data);
    step();
    write_en = 1'b0;
  endtask

  // Strobe monitor: each strobe must match the oldest expected entry, with the counter
  // already one past the entry's timestamp.
  always @(negedge CLK100MHZ) begin
    if (resetn && counter_matched) begin
      strobe_cnt++;
      chk("strobe_while_running", 128'(running), 128'(1));
      chk("strobe_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        exp_e   = sb.pop_front();
        exp_cnt = exp_e[95:32] + 64'd1;
        chk("event_data", event_data, exp_e);
        chk("counter_at_strobe", 128'(counter), 128'(exp_cnt));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) step();
    resetn = 1'b1;
    step();
    chk("rst_fifo_empty", 128'(fifo_empty), 128'(1));
    chk("rst_fifo_full", 128'(fifo_full), 128'(0));
    chk("rst_fifo_count", 128'(fifo_count), 128'(0));
    chk("rst_running", 128'(running), 128'(0));
    chk("rst_halted", 128'(halted), 128'(0));
    chk("rst_counter", 128'(counter), 128'(0));
    chk("rst_event_data", event_data, 128'(0));
    chk("rst_late_error", 128'(late_error), 128'(0));
    chk("rst_overflow", 128'(overflow_error), 128'(0));
    chk("rst_late_count", 128'(late_count), 128'(0));

    // Three entries dispatched in order
    push(64'd5, 32'd1, 1'b1);
    push(64'd10, 32'd2, 1'b1);
    push(64'd11, 32'd3, 1'b1);
    chk("t1_count", 128'(fifo_count), 128'(3));
    start = 1'b1; step(); start = 1'b0;
    chk("t1_running", 128'(running), 128'(1));
    for (int i = 0; i < 40 && counter < 64'd20; i++) step();
    chk("t1_drained", 128'(sb.size()), 128'(0));
    chk("t1_empty", 128'(fifo_empty), 128'(1));
    chk("t1_strobes", 128'(strobe_cnt), 128'(3));
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    chk("t1_stop_wins", 128'(running), 128'(0));

    // Equal timestamps: second goes late and halts
    counter_clear = 1'b1; step(); counter_clear = 1'b0;
    chk("t2_cleared", 128'(counter), 128'(0));
    push(64'd3, 32'd4, 1'b1);
    push(64'd3, 32'd5, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 30 && !halted; i++) step();
    chk("t2_halted", 128'(halted), 128'(1));
    chk("t2_late_error", 128'(late_error), 128'(1));
    chk("t2_late_count", 128'(late_count), 128'(1));
    chk("t2_late_data", late_data, mk(64'd3, 32'd5));
    chk("t2_counter", 128'(counter), 128'(5));
    repeat (3) step();
    chk("t2_frozen", 128'(counter), 128'(5));
    start = 1'b1; step(); start = 1'b0;
    chk("t2_start_in_halt", 128'(halted), 128'(1));
    error_clear = 1'b1; step(); error_clear = 1'b0;
    chk("t2_unhalted", 128'(halted), 128'(0));
    chk("t2_idle", 128'(running), 128'(0));
    chk("t2_late_cleared", 128'(late_error), 128'(0));
    chk("t2_late_count_cleared", 128'(late_count), 128'(0));
    chk("t2_late_data_kept", late_data, mk(64'd3, 32'd5));

    // Fill and overflow
    counter_clear = 1'b1; step(); counter_clear = 1'b0;
    for (int i = 0; i < 16; i++) push(64'd1000 + 64'(i), 32'(16 + i), 1'b1);
    chk("t3_full", 128'(fifo_full), 128'(1));
    chk("t3_count16", 128'(fifo_count), 128'(16));
    chk("t3_no_ovf_yet", 128'(overflow_error), 128'(0));
    push(64'd3000, 32'd99, 1'b0);
    chk("t3_overflow", 128'(overflow_error), 128'(1));
    chk("t3_count_kept", 128'(fifo_count), 128'(16));
    error_clear = 1'b1; step(); error_clear = 1'b0;
    chk("t3_ovf_cleared", 128'(overflow_error), 128'(0));

    // Push while full in the same cycle as a pop
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 1100 && counter != 64'd1000; i++) step();
    chk("t4_reach_head", 128'(counter), 128'(1000));
    write_en = 1'b1; write_data = mk(64'd2000, 32'd50); step(); write_en = 1'b0;
    chk("t4_count_same", 128'(fifo_count), 128'(16));
    chk("t4_full_same", 128'(fifo_full), 128'(1));
    chk("t4_no_ovf", 128'(overflow_error), 128'(0));
    for (int i = 0; i < 40 && counter < 64'd1020; i++) step();
    chk("t4_drained", 128'(sb.size()), 128'(0));
    chk("t4_one_left", 128'(fifo_count), 128'(1));
    stop = 1'b1; step(); stop = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("t4_flushed", 128'(fifo_empty), 128'(1));

    // Asynchronous reset while running with entries queued
    counter_clear = 1'b1; step(); counter_clear = 1'b0;
    for (int i = 0; i < 4; i++) push(64'd50 + 64'(i), 32'(70 + i), 1'b0);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    #2 resetn = 1'b0;
    #1;
    chk("t5_counter", 128'(counter), 128'(0));
    chk("t5_running", 128'(running), 128'(0));
    chk("t5_empty", 128'(fifo_empty), 128'(1));
    chk("t5_count", 128'(fifo_count), 128'(0));
    chk("t5_late_data", late_data, 128'(0));
    chk("t5_event_data", event_data, 128'(0));
    repeat (2) step();
    resetn = 1'b1;
    s0 = strobe_cnt;
    repeat (80) step();
    chk("t5_no_strobe", 128'(strobe_cnt - s0), 128'(0));
    chk("t5_counter_idle", 128'(counter), 128'(0));

    // Counter wrap
    push(64'hFFFF_FFFF_FFFF_FFFF, 32'd60, 1'b1);
    push(64'd0, 32'd61, 1'b1);
    force dut.counter_q = 64'hFFFF_FFFF_FFFF_FFFD;
    step();
    release dut.counter_q;
    chk("t6_preload", 128'(counter), 128'(64'hFFFF_FFFF_FFFF_FFFD));
    s0 = strobe_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    repeat (2) step();
    chk("t6_drained", 128'(sb.size()), 128'(0));
    chk("t6_strobes", 128'(strobe_cnt - s0), 128'(2));
    chk("t6_not_late", 128'(late_error), 128'(0));
    chk("t6_empty", 128'(fifo_empty), 128'(1));
    stop = 1'b1; step(); stop = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
